// File: rtl/ls299.sv
// ls299: 8-bit universal shift/storage register with 3-state I/O.
// The register holds, shifts right, shifts left or loads a parallel word.
// Tristate gating of the I/O pins is left to the instantiating wrapper,
// which uses IO_OE to decide when IO_OUT actually drives the pins.
module ls299 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             S0,
    input  logic             S1,
    input  logic             OE1_n,
    input  logic             OE2_n,
    input  logic             SR,
    input  logic             SL,
    input  logic [WIDTH-1:0] IO_IN,
    output logic [WIDTH-1:0] IO_OUT,
    output logic             IO_OE,
    output logic             QA_S,
    output logic             QH_S
);

    logic [WIDTH-1:0] r_q;
    logic [1:0]       w_mode;

    assign w_mode = {S1, S0};

    // Register update: clear wins, then hold / shift right / shift left / load.
    // An unknown mode select poisons the whole word so the problem is
    // visible downstream in simulation.
    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            r_q <= '0;
        end else begin
            case (w_mode)
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= {r_q[WIDTH-2:0], SR};
                2'b10:   r_q <= {SL, r_q[WIDTH-1:1]};
                2'b11:   r_q <= IO_IN;
                default: r_q <= 'x;
            endcase
        end
    end

    // Outputs: the bus is released whenever either enable is high or the
    // part is in load mode, so an external driver can present IO_IN.
    always_comb begin
        IO_OUT = r_q;
        QA_S   = r_q[0];
        QH_S   = r_q[WIDTH-1];
        IO_OE  = ~OE1_n & ~OE2_n & ~(S1 & S0);
    end

endmodule

// File: tb/tb_ls299.sv
// tb_ls299: directed and random checks of ls299 against an arithmetic
// model of the register, plus a two-part cascade.
module tb_ls299;

    logic       CLK = 1'b0;
    logic       CLR_n, S0, S1, OE1_n, OE2_n, SR, SL;
    logic [7:0] IO_IN;
    logic [7:0] IO_OUT;
    logic       IO_OE, QA_S, QH_S;

    // cascade pair
    logic       c_clr_n, c_s0, c_s1, c_sr_lo, c_sl_hi;
    logic [7:0] c_in_lo, c_in_hi, c_out_lo, c_out_hi;
    logic       c_oe_lo, c_oe_hi, c_qa_lo, c_qh_lo, c_qa_hi, c_qh_hi;

    int checks = 0;
    int errors = 0;
    int m_q;     // model register as an integer 0..255
    int c_m;     // model of cascade as one 16-bit value {hi,lo}

    always #5 CLK = ~CLK;

    ls299 #(.WIDTH(8)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .S0(S0), .S1(S1), .OE1_n(OE1_n), .OE2_n(OE2_n),
        .SR(SR), .SL(SL), .IO_IN(IO_IN), .IO_OUT(IO_OUT), .IO_OE(IO_OE),
        .QA_S(QA_S), .QH_S(QH_S)
    );

    ls299 #(.WIDTH(8)) u_lo (
        .CLK(CLK), .CLR_n(c_clr_n), .S0(c_s0), .S1(c_s1), .OE1_n(1'b0), .OE2_n(1'b0),
        .SR(c_sr_lo), .SL(c_qa_hi), .IO_IN(c_in_lo), .IO_OUT(c_out_lo), .IO_OE(c_oe_lo),
        .QA_S(c_qa_lo), .QH_S(c_qh_lo)
    );

    ls299 #(.WIDTH(8)) u_hi (
        .CLK(CLK), .CLR_n(c_clr_n), .S0(c_s0), .S1(c_s1), .OE1_n(1'b0), .OE2_n(1'b0),
        .SR(c_qh_lo), .SL(c_sl_hi), .IO_IN(c_in_hi), .IO_OUT(c_out_hi), .IO_OE(c_oe_hi),
        .QA_S(c_qa_hi), .QH_S(c_qh_hi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; model computes the next value from the mode rules
    task automatic tick();
        int nq;
        nq = m_q;
        if (!CLR_n) nq = 0;
        else if (!S1 && S0) nq = (m_q * 2 + int'(SR)) % 256;
        else if (S1 && !S0) nq = m_q / 2 + int'(SL) * 128;
        else if (S1 && S0) nq = int'(IO_IN);
        @(posedge CLK);
        #1;
        m_q = nq;
    endtask

    task automatic chk_all(input string tag);
        int exp_oe;
        exp_oe = (!OE1_n && !OE2_n && !(S1 && S0)) ? 1 : 0;
        chk({tag, ".q"},  32'(IO_OUT), 32'(m_q));
        chk({tag, ".qa"}, 32'(QA_S),   32'(m_q % 2));
        chk({tag, ".qh"}, 32'(QH_S),   32'(m_q / 128));
        chk({tag, ".oe"}, 32'(IO_OE),  32'(exp_oe));
    endtask

    task automatic set_mode(input logic s1, input logic s0);
        S1 = s1;
        S0 = s0;
    endtask

    initial begin
        CLR_n = 1'b1; OE1_n = 1'b0; OE2_n = 1'b0; SR = 1'b0; SL = 1'b0;
        IO_IN = 8'h00; set_mode(1'b0, 1'b0);
        c_clr_n = 1'b1; c_s0 = 1'b0; c_s1 = 1'b0; c_sr_lo = 1'b0; c_sl_hi = 1'b0;
        c_in_lo = 8'h00; c_in_hi = 8'h00;
        m_q = 0;
        #2;

        // reset overrides load
        CLR_n = 1'b0; set_mode(1'b1, 1'b1); IO_IN = 8'hFF;
        tick();
        chk_all("reset");
        chk("reset.val", 32'(IO_OUT), 32'h00);
        CLR_n = 1'b1; set_mode(1'b0, 1'b0);
        tick();
        chk_all("hold0");

        // load A5 then serialise right with SR=0
        set_mode(1'b1, 1'b1); IO_IN = 8'hA5;
        #1 chk("load.oe_during", 32'(IO_OE), 32'h0);
        tick();
        chk("load.val", 32'(IO_OUT), 32'hA5);
        set_mode(1'b0, 1'b1); SR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all($sformatf("shr%0d", i));
        end
        chk("shr.final", 32'(IO_OUT), 32'h00);

        // deserialise left
        set_mode(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            SL = ((8'h53 >> i) & 8'h01) != 0;
            tick();
            chk_all($sformatf("shl%0d", i));
        end
        chk("shl.final", 32'(IO_OUT), 32'h53);

        // output enable matrix
        set_mode(1'b1, 1'b1); IO_IN = 8'h3C; tick();
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            OE1_n = i[0]; OE2_n = i[1];
            #1 chk($sformatf("oe%0d.oe", i), 32'(IO_OE), (i == 0) ? 32'h1 : 32'h0);
            tick();
            chk($sformatf("oe%0d.q", i), 32'(IO_OUT), 32'h3C);
        end
        OE1_n = 1'b0; OE2_n = 1'b0; set_mode(1'b1, 1'b1);
        #1 chk("oe_load.oe", 32'(IO_OE), 32'h0);
        chk("oe_load.q", 32'(IO_OUT), 32'h3C);

        // clear mid-shift
        IO_IN = 8'hFF; tick();
        set_mode(1'b0, 1'b1); SR = 1'b0;
        repeat (3) tick();
        chk("mid.f8", 32'(IO_OUT), 32'hF8);
        CLR_n = 1'b0; tick();
        chk("mid.clr", 32'(IO_OUT), 32'h00);
        CLR_n = 1'b1; SR = 1'b1; tick();
        chk("mid.after", 32'(IO_OUT), 32'h01);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            CLR_n = ($urandom_range(0, 15) != 0);
            S0 = $urandom_range(0, 1); S1 = $urandom_range(0, 1);
            OE1_n = $urandom_range(0, 1); OE2_n = $urandom_range(0, 1);
            SR = $urandom_range(0, 1); SL = $urandom_range(0, 1);
            IO_IN = 8'($urandom);
            tick();
            chk_all("rnd");
        end

        // cascade: load lo=81 hi=00, shift right 8 times as one 16-bit word
        c_s1 = 1'b1; c_s0 = 1'b1; c_in_lo = 8'h81; c_in_hi = 8'h00;
        @(posedge CLK); #1;
        c_m = 16'h0081;
        chk("cas.load", {16'h0, c_out_hi, c_out_lo}, 32'(c_m));
        c_s1 = 1'b0; c_s0 = 1'b1; c_sr_lo = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            c_m = (c_m * 2) % 65536;
            chk($sformatf("cas%0d", i), {16'h0, c_out_hi, c_out_lo}, 32'(c_m));
        end
        chk("cas.hi", 32'(c_out_hi), 32'h81);
        chk("cas.lo", 32'(c_out_lo), 32'h00);

        // cascade shift left: hi's QA feeds lo's SL
        c_s1 = 1'b1; c_s0 = 1'b0; c_sl_hi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            c_m = c_m / 2 + 32768;
            chk($sformatf("casl%0d", i), {16'h0, c_out_hi, c_out_lo}, 32'(c_m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
